// File: rtl/cpu_psr_pkg.sv
// Shared definitions for the CPU processor-status register: 6502 flag
// positions, default reset/constant-bit values and the LIFO depth width.
package cpu_psr_pkg;

  localparam int PSR_C = 0;
  localparam int PSR_Z = 1;
  localparam int PSR_I = 2;
  localparam int PSR_D = 3;
  localparam int PSR_B = 4;
  localparam int PSR_U = 5;
  localparam int PSR_V = 6;
  localparam int PSR_N = 7;

  localparam logic [7:0] PSR_RST_VAL    = 8'h24;
  localparam logic [7:0] PSR_FIXED_MASK = 8'h20;
  localparam logic [7:0] PSR_FIXED_VAL  = 8'h20;

  // Bits needed to count 0..depth occupied entries.
  function automatic int depth_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/psr_lifo.sv
// Shadow LIFO for saved status words. Entries live in a circular buffer so
// that, in wrap mode, a push into a full stack can retire the oldest entry by
// advancing the base pointer instead of shifting the whole array.
module psr_lifo
  import cpu_psr_pkg::*;
#(
  parameter int W        = 8,
  parameter int DEPTH    = 4,
  parameter bit OVF_WRAP = 1'b0,
  parameter int DW       = depth_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_x,
  input  logic          cen,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top_data,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] base;
  logic [DW-1:0] count;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] base_nxt;
  logic          do_xchg;
  logic          do_pop;
  logic          do_push;
  logic          do_wrap;

  // Physical slot of logical entry 'off' counted from the oldest entry.
  function automatic logic [AW-1:0] slot(input logic [AW-1:0] b, input int unsigned off);
    int unsigned sum;
    sum = 32'(b) + off;
    return AW'(sum % unsigned'(DEPTH));
  endfunction

  assign full     = (count == DW'(DEPTH));
  assign empty    = (count == '0);
  assign depth    = count;
  assign top_idx  = slot(base, 32'(count) + unsigned'(DEPTH) - 1);
  assign wr_idx   = slot(base, 32'(count));
  assign base_nxt = slot(base, 1);
  assign top_data = mem[top_idx];

  // Push+pop with something saved is an in-place exchange of the top entry;
  // with nothing saved the pop is void and the push goes ahead.
  assign do_xchg = push & pop & ~empty;
  assign do_pop  = pop & ~push & ~empty;
  assign do_push = push & ~do_xchg & ~full;
  assign do_wrap = (OVF_WRAP != 1'b0) & push & ~pop & full;

  // Storage array; contents are meaningless while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (cen) begin
      if (do_xchg)      mem[top_idx] <= push_data;
      else if (do_push) mem[wr_idx]  <= push_data;
      else if (do_wrap) mem[base]    <= push_data;
    end
  end

  // Occupancy and circular base pointer.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      count <= '0;
      base  <= '0;
    end else if (cen) begin
      if (do_push)     count <= count + 1'b1;
      else if (do_pop) count <= count - 1'b1;
      if (do_wrap)     base  <= base_nxt;
    end
  end

endmodule

// File: rtl/cpu_status_reg_stack.sv
// CPU processor-status register with per-bit masked update, whole-word load,
// constant bits and a hardware shadow LIFO for nested interrupt context save.
module cpu_status_reg_stack
  import cpu_psr_pkg::*;
#(
  parameter int           W          = 8,
  parameter int           DEPTH      = 4,
  parameter logic [W-1:0] RST_VAL    = W'(PSR_RST_VAL),
  parameter logic [W-1:0] FIXED_MASK = W'(PSR_FIXED_MASK),
  parameter logic [W-1:0] FIXED_VAL  = W'(PSR_FIXED_VAL),
  parameter bit           OVF_WRAP   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_x,
  input  logic                      cen,
  input  logic [W-1:0]              i_wr_mask,
  input  logic [W-1:0]              i_wr_data,
  input  logic                      i_load,
  input  logic [W-1:0]              i_load_data,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic                      i_clr_err,
  output logic [W-1:0]              o_psr,
  output logic [depth_w(DEPTH)-1:0] o_depth,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_ovf,
  output logic                      o_unf
);

  localparam logic [W-1:0] FIX_BITS = FIXED_VAL & FIXED_MASK;
  localparam logic [W-1:0] RST_PSR  = (RST_VAL & ~FIXED_MASK) | FIX_BITS;

  logic [W-1:0] psr;
  logic [W-1:0] psr_sel;
  logic [W-1:0] psr_nxt;
  logic [W-1:0] lifo_top;
  logic         lifo_full;
  logic         lifo_empty;
  logic         valid_pop;
  logic         ovf_evt;
  logic         unf_evt;
  logic         ovf;
  logic         unf;

  psr_lifo #(
    .W        (W),
    .DEPTH    (DEPTH),
    .OVF_WRAP (OVF_WRAP)
  ) u_lifo (
    .clk       (clk),
    .rst_x     (rst_x),
    .cen       (cen),
    .push      (i_push),
    .pop       (i_pop),
    .push_data (psr),
    .top_data  (lifo_top),
    .depth     (o_depth),
    .full      (lifo_full),
    .empty     (lifo_empty)
  );

  // An exchange (push+pop while occupied) is not an overflow even when full.
  assign valid_pop = i_pop & ~lifo_empty;
  assign ovf_evt   = i_push & ~i_pop & lifo_full;
  assign unf_evt   = i_pop & lifo_empty;

  // Next-status priority: restore from LIFO, then load, then masked update.
  always_comb begin
    psr_sel = psr;
    if (valid_pop)   psr_sel = lifo_top;
    else if (i_load) psr_sel = i_load_data;
    else             psr_sel = (psr & ~i_wr_mask) | (i_wr_data & i_wr_mask);
    psr_nxt = (psr_sel & ~FIXED_MASK) | FIX_BITS;
  end

  // Status word and sticky error flags; a fresh error outranks the clear.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      psr <= RST_PSR;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (cen) begin
      psr <= psr_nxt;
      ovf <= ovf_evt | (ovf & ~i_clr_err);
      unf <= unf_evt | (unf & ~i_clr_err);
    end
  end

  assign o_psr   = psr;
  assign o_full  = lifo_full;
  assign o_empty = lifo_empty;
  assign o_ovf   = ovf;
  assign o_unf   = unf;

endmodule

// File: tb/tb_cpu_status_reg_stack.sv
// Bench for cpu_status_reg_stack: one drop-on-overflow and one wrap-on-overflow
// instance share stimulus and are compared with a queue-based reference model.
module tb_cpu_status_reg_stack;
  import cpu_psr_pkg::*;

  logic       clk = 1'b0;
  logic       rst_x = 1'b0;
  logic       cen = 1'b0, push = 1'b0, pop = 1'b0, load = 1'b0, clr = 1'b0;
  logic [7:0] mask = 8'h00, wdata = 8'h00, ldata = 8'h00;

  logic [7:0] psr_o   [2];
  logic [2:0] depth_o [2];
  logic       full_o  [2];
  logic       empty_o [2];
  logic       ovf_o   [2];
  logic       unf_o   [2];

  logic [7:0] m_psr [2];
  logic       m_ovf [2];
  logic       m_unf [2];
  logic [7:0] mq    [2][$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_status_reg_stack #(.OVF_WRAP(1'b0)) u_drop (
    .clk(clk), .rst_x(rst_x), .cen(cen), .i_wr_mask(mask), .i_wr_data(wdata),
    .i_load(load), .i_load_data(ldata), .i_push(push), .i_pop(pop), .i_clr_err(clr),
    .o_psr(psr_o[0]), .o_depth(depth_o[0]), .o_full(full_o[0]), .o_empty(empty_o[0]),
    .o_ovf(ovf_o[0]), .o_unf(unf_o[0]));

  cpu_status_reg_stack #(.OVF_WRAP(1'b1)) u_wrap (
    .clk(clk), .rst_x(rst_x), .cen(cen), .i_wr_mask(mask), .i_wr_data(wdata),
    .i_load(load), .i_load_data(ldata), .i_push(push), .i_pop(pop), .i_clr_err(clr),
    .o_psr(psr_o[1]), .o_depth(depth_o[1]), .o_full(full_o[1]), .o_empty(empty_o[1]),
    .o_ovf(ovf_o[1]), .o_unf(unf_o[1]));

  function automatic logic [7:0] fix(input logic [7:0] x);
    return (x & ~8'h20) | 8'h20;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_psr[k] = 8'h24;
      m_ovf[k] = 1'b0;
      m_unf[k] = 1'b0;
      mq[k].delete();
    end
  endtask

  // Reference behaviour: a queue whose back is the LIFO top; instance 1 wraps.
  task automatic model_clock(input int k);
    int         sz;
    logic [7:0] nxt;
    logic       oe, ue;
    sz = mq[k].size();
    if (!cen) return;
    oe = push && !pop && (sz == 4);
    ue = pop && (sz == 0);
    if (pop && sz > 0) nxt = mq[k][sz-1];
    else if (load)     nxt = ldata;
    else               nxt = (m_psr[k] & ~mask) | (wdata & mask);
    if (push && pop && sz > 0) mq[k][sz-1] = m_psr[k];
    else if (pop && sz > 0)    void'(mq[k].pop_back());
    else if (push) begin
      if (sz < 4) mq[k].push_back(m_psr[k]);
      else if (k == 1) begin
        void'(mq[k].pop_front());
        mq[k].push_back(m_psr[k]);
      end
    end
    m_ovf[k] = oe | (m_ovf[k] & ~clr);
    m_unf[k] = ue | (m_unf[k] & ~clr);
    m_psr[k] = fix(nxt);
  endtask

  // Apply one cycle of stimulus from a negedge, return at the next negedge.
  task automatic step(input logic c, input logic ps, input logic po, input logic ld,
                      input logic cl, input logic [7:0] m, input logic [7:0] d,
                      input logic [7:0] l);
    cen = c; push = ps; pop = po; load = ld; clr = cl; mask = m; wdata = d; ldata = l;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_clock(k);
    @(negedge clk);
    cen = 1'b0; push = 1'b0; pop = 1'b0; load = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      obs = {psr_o[k], depth_o[k], full_o[k], empty_o[k], ovf_o[k], unf_o[k]};
      n_checks++;
      if (obs !== {8'h24, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h want %h", k, obs, {8'h24, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
      end
    end
    rst_x = 1'b1;
    model_reset();
  endtask

  task automatic test_mask_load();
    logic [7:0] m;
    m = 8'h00;
    m[PSR_N] = 1'b1;
    m[PSR_C] = 1'b1;
    step(1, 0, 0, 0, 0, m, 8'h80, 8'h00);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (psr_o[k] !== 8'hA4 || m_psr[k] !== 8'hA4) begin
        n_fail++;
        $display("FAIL mask[%0d]: got %h want A4", k, psr_o[k]);
      end
    end
    step(0, 1, 1, 1, 0, 8'hFF, 8'h00, 8'hFF);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({psr_o[k], depth_o[k], unf_o[k]} !== {8'hA4, 3'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL cen_hold[%0d]: got %h/%0d/%b want A4/0/0", k, psr_o[k], depth_o[k], unf_o[k]);
      end
    end
    step(1, 0, 0, 1, 0, 8'hFF, 8'hFF, 8'h00);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (psr_o[k] !== 8'h20) begin
        n_fail++;
        $display("FAIL load_fixed[%0d]: got %h want 20", k, psr_o[k]);
      end
    end
  endtask

  task automatic test_push_pop();
    logic [7:0] m;
    m = 8'h00;
    m[PSR_I] = 1'b1;
    step(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'hA4);
    step(1, 1, 0, 0, 0, m, 8'hFF, 8'h00);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({psr_o[k], depth_o[k], empty_o[k]} !== {8'hA4, 3'd1, 1'b0}) begin
        n_fail++;
        $display("FAIL push_irq[%0d]: got %h/%0d want A4/1", k, psr_o[k], depth_o[k]);
      end
    end
    step(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'hFF);
    step(1, 0, 1, 1, 0, 8'hFF, 8'h00, 8'h00);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({psr_o[k], depth_o[k], empty_o[k], unf_o[k]} !== {8'hA4, 3'd0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL pop_restore[%0d]: got %h/%0d/%b want A4/0/1", k, psr_o[k], depth_o[k], empty_o[k]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] e [2][5];
    e[0] = '{8'h24, 8'h23, 8'h22, 8'h21, 8'h21};
    e[1] = '{8'h25, 8'h24, 8'h23, 8'h22, 8'h22};
    step(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h21);
    for (int i = 2; i <= 5; i++) step(1, 1, 0, 1, 0, 8'h00, 8'h00, 8'(8'h20 + i));
    step(1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({ovf_o[k], depth_o[k], full_o[k]} !== {1'b1, 3'd4, 1'b1}) begin
        n_fail++;
        $display("FAIL overflow[%0d]: ovf %b depth %0d want 1/4", k, ovf_o[k], depth_o[k]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (psr_o[k] !== e[k][i] || psr_o[k] !== m_psr[k]) begin
          n_fail++;
          $display("FAIL pop_order[%0d] #%0d: got %h want %h", k, i, psr_o[k], e[k][i]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({unf_o[k], depth_o[k]} !== {1'b1, 3'd0}) begin
        n_fail++;
        $display("FAIL underflow[%0d]: unf %b depth %0d want 1/0", k, unf_o[k], depth_o[k]);
      end
    end
    step(1, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({ovf_o[k], unf_o[k]} !== 2'b00) begin
        n_fail++;
        $display("FAIL clr_err[%0d]: ovf %b unf %b want 0/0", k, ovf_o[k], unf_o[k]);
      end
    end
    step(1, 0, 1, 0, 1, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (unf_o[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL clr_vs_new[%0d]: unf %b want 1", k, unf_o[k]);
      end
    end
  endtask

  task automatic test_exchange();
    logic [14:0] obs;
    step(1, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    step(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'hE3);
    step(1, 1, 0, 1, 0, 8'h00, 8'h00, 8'h61);
    step(1, 1, 1, 1, 0, 8'hFF, 8'h00, 8'h00);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({psr_o[k], depth_o[k], ovf_o[k], unf_o[k]} !== {8'hE3, 3'd1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL exchange[%0d]: got %h/%0d want E3/1", k, psr_o[k], depth_o[k]);
      end
    end
    step(1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (psr_o[k] !== 8'h61) begin
        n_fail++;
        $display("FAIL exchange_top[%0d]: got %h want 61", k, psr_o[k]);
      end
    end
    step(1, 1, 1, 1, 0, 8'h00, 8'h00, 8'h8F);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({psr_o[k], depth_o[k], unf_o[k]} !== {8'hAF, 3'd1, 1'b1}) begin
        n_fail++;
        $display("FAIL pushpop_empty[%0d]: got %h/%0d/%b want AF/1/1", k, psr_o[k], depth_o[k], unf_o[k]);
      end
    end
    #2 rst_x = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      obs = {psr_o[k], depth_o[k], full_o[k], empty_o[k], ovf_o[k], unf_o[k]};
      n_checks++;
      if (obs !== {8'h24, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL async_reset[%0d]: got %h", k, obs);
      end
    end
    @(negedge clk);
    rst_x = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic [14:0] obs, exp;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(9) != 0, $urandom_range(2) == 0, $urandom_range(2) == 0,
           $urandom_range(4) == 0, $urandom_range(9) == 0,
           8'($urandom), 8'($urandom), 8'($urandom));
      for (int k = 0; k < 2; k++) begin
        obs = {psr_o[k], depth_o[k], full_o[k], empty_o[k], ovf_o[k], unf_o[k]};
        exp = {m_psr[k], 3'(mq[k].size()), mq[k].size() == 4, mq[k].size() == 0,
               m_ovf[k], m_unf[k]};
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL random[%0d] cycle %0d: got %h want %h", k, i, obs, exp);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mask_load();
    test_push_pop();
    test_overflow();
    test_exchange();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
